// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and unified memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // Instruction-fetch requester
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_ack;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_stall;

  // Data-side requester
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_ack;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_stall;

  // Unified memory port
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic                 busy;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
    output mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  // Requester / memory model side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/data) arbiter onto one fixed-latency memory port
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2
) (
  input logic             clk,
  input logic             reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  // last_grant encoding: 0 = fetch side, 1 = data side
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_cnt;
  logic                 r_last_grant;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_we;

  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_done;
  logic                 w_i_ack;
  logic                 w_d_ack;

  assign w_done = (r_cnt == 3'd0);

  // Arbitrate in IDLE only; a busy phase ends after its counter reaches zero
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the side that was not served last wins
        if (bus.d_req && (!bus.i_req || (r_last_grant == GRANT_I))) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (bus.i_req) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the granted request and run the access down-counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt        <= 3'd0;
      r_last_grant <= GRANT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
    end else if (w_grant_d) begin
      r_cnt        <= CNT_LOAD;
      r_last_grant <= GRANT_D;
      r_addr       <= bus.d_addr;
      r_wdata      <= bus.d_wdata;
      r_we         <= bus.d_we;
    end else if (w_grant_i) begin
      r_cnt        <= CNT_LOAD;
      r_last_grant <= GRANT_I;
      r_addr       <= bus.i_addr;
      r_wdata      <= '0;
      r_we         <= 1'b0;
    end else if ((r_state != IDLE) && !w_done) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign w_i_ack = (r_state == BUSY_I) && w_done;
  assign w_d_ack = (r_state == BUSY_D) && w_done;

  // Memory side is driven only from the captured request
  assign bus.mem_read  = (r_state == BUSY_I) || ((r_state == BUSY_D) && !r_we);
  assign bus.mem_write = (r_state == BUSY_D) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != IDLE);

  // Requester side: read data is only presented alongside its ack
  assign bus.i_ack   = w_i_ack;
  assign bus.i_rdata = w_i_ack ? bus.mem_rdata : '0;
  assign bus.i_stall = bus.i_req && !w_i_ack;
  assign bus.d_ack   = w_d_ack;
  assign bus.d_rdata = (w_d_ack && !r_we) ? bus.mem_rdata : '0;
  assign bus.d_stall = bus.d_req && !w_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.WORD_SIZE(16)) ifa ();
  mem_port_arbiter_if #(.WORD_SIZE(16)) ifb ();

  mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(2)) u_dut_l2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(1)) u_dut_l1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    ifa.i_req = 1'b0; ifa.i_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    ifa.d_addr = '0; ifa.d_wdata = '0; ifa.mem_rdata = 16'h5A5A;
    ifb.i_req = 1'b0; ifb.i_addr = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
    ifb.d_addr = '0; ifb.d_wdata = '0; ifb.mem_rdata = 16'hA5A5;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_busy",      32'(ifa.busy),      32'd0);
    chk("rst_mem_read",  32'(ifa.mem_read),  32'd0);
    chk("rst_mem_write", 32'(ifa.mem_write), 32'd0);
    chk("rst_mem_addr",  32'(ifa.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(ifa.mem_wdata), 32'd0);
    chk("rst_i_ack",     32'(ifa.i_ack),     32'd0);
    chk("rst_d_ack",     32'(ifa.d_ack),     32'd0);
    chk("rst_i_rdata",   32'(ifa.i_rdata),   32'd0);
    chk("rst_d_rdata",   32'(ifa.d_rdata),   32'd0);
    chk("rst_i_stall",   32'(ifa.i_stall),   32'd0);
    chk("rst_d_stall",   32'(ifa.d_stall),   32'd0);
    chk("rst_b_busy",    32'(ifb.busy),      32'd0);

    // Single fetch, LATENCY=2
    tick();
    reset_n = 1'b1;
    ifa.i_req = 1'b1; ifa.i_addr = 16'h0010; ifa.mem_rdata = 16'hB000;
    #1;
    chk("t1_c0_busy",    32'(ifa.busy),     32'd0);
    chk("t1_c0_stall",   32'(ifa.i_stall),  32'd1);
    tick();
    chk("t1_c1_read",    32'(ifa.mem_read), 32'd1);
    chk("t1_c1_addr",    32'(ifa.mem_addr), 32'h0010);
    chk("t1_c1_ack",     32'(ifa.i_ack),    32'd0);
    chk("t1_c1_rdata",   32'(ifa.i_rdata),  32'd0);
    tick();
    chk("t1_c2_read",    32'(ifa.mem_read), 32'd1);
    chk("t1_c2_ack",     32'(ifa.i_ack),    32'd1);
    chk("t1_c2_rdata",   32'(ifa.i_rdata),  32'hB000);
    chk("t1_c2_stall",   32'(ifa.i_stall),  32'd0);
    tick();
    ifa.i_req = 1'b0;
    #1;
    chk("t1_c3_busy",    32'(ifa.busy),     32'd0);
    chk("t1_c3_read",    32'(ifa.mem_read), 32'd0);

    // Tie from reset: D, then I, then D again
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ifa.i_req = 1'b1; ifa.i_addr = 16'h0020;
    ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 16'h0040;
    ifa.mem_rdata = 16'hC000;
    #1;
    tick();
    chk("t2_c1_read",    32'(ifa.mem_read), 32'd1);
    chk("t2_c1_addr",    32'(ifa.mem_addr), 32'h0040);
    chk("t2_c1_istall",  32'(ifa.i_stall),  32'd1);
    tick();
    chk("t2_c2_dack",    32'(ifa.d_ack),    32'd1);
    chk("t2_c2_drdata",  32'(ifa.d_rdata),  32'hC000);
    chk("t2_c2_iack",    32'(ifa.i_ack),    32'd0);
    chk("t2_c2_dstall",  32'(ifa.d_stall),  32'd0);
    tick();
    chk("t2_c3_busy",    32'(ifa.busy),     32'd0);
    chk("t2_c3_dack",    32'(ifa.d_ack),    32'd0);
    tick();
    chk("t2_c4_addr",    32'(ifa.mem_addr), 32'h0020);
    chk("t2_c4_read",    32'(ifa.mem_read), 32'd1);
    chk("t2_c4_irdata",  32'(ifa.i_rdata),  32'd0);
    tick();
    chk("t2_c5_iack",    32'(ifa.i_ack),    32'd1);
    chk("t2_c5_irdata",  32'(ifa.i_rdata),  32'hC000);
    chk("t2_c5_dack",    32'(ifa.d_ack),    32'd0);
    tick();
    chk("t2_c6_busy",    32'(ifa.busy),     32'd0);
    tick();
    chk("t2_c7_addr",    32'(ifa.mem_addr), 32'h0040);
    tick();
    chk("t2_c8_dack",    32'(ifa.d_ack),    32'd1);
    tick();
    ifa.i_req = 1'b0; ifa.d_req = 1'b0;
    #1;

    // Data write, inputs changed mid-access
    tick();
    ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 16'h00F0; ifa.d_wdata = 16'h1234;
    ifa.mem_rdata = 16'h7777;
    #1;
    chk("t3_c0_write",   32'(ifa.mem_write), 32'd0);
    tick();
    ifa.d_wdata = 16'hFFFF; ifa.d_addr = 16'h0BAD;
    #1;
    chk("t3_c1_write",   32'(ifa.mem_write), 32'd1);
    chk("t3_c1_read",    32'(ifa.mem_read),  32'd0);
    chk("t3_c1_wdata",   32'(ifa.mem_wdata), 32'h1234);
    chk("t3_c1_addr",    32'(ifa.mem_addr),  32'h00F0);
    tick();
    chk("t3_c2_write",   32'(ifa.mem_write), 32'd1);
    chk("t3_c2_wdata",   32'(ifa.mem_wdata), 32'h1234);
    chk("t3_c2_dack",    32'(ifa.d_ack),     32'd1);
    chk("t3_c2_drdata",  32'(ifa.d_rdata),   32'd0);
    tick();
    ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    #1;
    chk("t3_c3_write",   32'(ifa.mem_write), 32'd0);

    // Fetch held continuously: one access per LATENCY+1 cycles
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 0) begin
        ifa.i_req = 1'b1; ifa.i_addr = 16'h0030; ifa.mem_rdata = 16'h3333;
      end
      #1;
      chk($sformatf("t4_c%0d_iack", k),   32'(ifa.i_ack),   (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t4_c%0d_istall", k), 32'(ifa.i_stall), (k % 3 == 2) ? 32'd0 : 32'd1);
    end
    tick();
    ifa.i_req = 1'b0;
    #1;

    // Reset in the middle of a data read abandons it
    tick();
    ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 16'h0050;
    #1;
    chk("t5_c0_dstall",  32'(ifa.d_stall),   32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_c1_busy",    32'(ifa.busy),      32'd1);
    chk("t5_c1_read",    32'(ifa.mem_read),  32'd1);
    tick();
    reset_n = 1'b1;
    ifa.d_req = 1'b0;
    #1;
    chk("t5_c2_busy",    32'(ifa.busy),      32'd0);
    chk("t5_c2_read",    32'(ifa.mem_read),  32'd0);
    chk("t5_c2_write",   32'(ifa.mem_write), 32'd0);
    chk("t5_c2_dack",    32'(ifa.d_ack),     32'd0);
    chk("t5_c2_addr",    32'(ifa.mem_addr),  32'd0);
    tick();
    chk("t5_c3_dack",    32'(ifa.d_ack),     32'd0);

    // LATENCY=1 instance: single-cycle access, address captured at grant
    tick();
    ifb.i_req = 1'b1; ifb.i_addr = 16'h0060; ifb.mem_rdata = 16'hD000;
    #1;
    chk("t6_c0_busy",    32'(ifb.busy),      32'd0);
    tick();
    ifb.i_addr = 16'h0070;
    #1;
    chk("t6_c1_read",    32'(ifb.mem_read),  32'd1);
    chk("t6_c1_addr",    32'(ifb.mem_addr),  32'h0060);
    chk("t6_c1_iack",    32'(ifb.i_ack),     32'd1);
    chk("t6_c1_irdata",  32'(ifb.i_rdata),   32'hD000);
    chk("t6_c1_istall",  32'(ifb.i_stall),   32'd0);
    tick();
    ifb.i_req = 1'b0;
    #1;
    chk("t6_c2_read",    32'(ifb.mem_read),  32'd0);
    chk("t6_c2_busy",    32'(ifb.busy),      32'd0);
    chk("t6_c2_addr",    32'(ifb.mem_addr),  32'h0060);
    chk("t6_c2_iack",    32'(ifb.i_ack),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
